multi_ce_gen: RTL and testbench

MULTI_CE_GEN -- requirements
Module: multi_ce_gen

---
 rtl/multi_ce_gen_pkg.sv | 10 +
 rtl/multi_ce_gen_if.sv | 16 +
 rtl/multi_ce_gen_chan.sv | 68 ++++++
 rtl/multi_ce_gen.sv | 27 ++
 tb/tb_multi_ce_gen.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/multi_ce_gen_pkg.sv
// uk101_ce_pkg: shared defaults, mode enum and channel indices for the clock-enable generator.
package uk101_ce_pkg;
    localparam int NUM_CH_DEF = 3;
    localparam int CNT_W_DEF  = 8;
    localparam int ACC_W_DEF  = 16;
    localparam int CE_PIX     = 0;
    localparam int CE_CPU     = 1;
    localparam int CE_BAUD    = 2;
    typedef enum logic {CE_INT = 1'b0, CE_FRAC = 1'b1} ce_mode_e;
endpackage

// File: rtl/multi_ce_gen_if.sv
// multi_ce_gen_if: per-channel control inputs and clock-enable outputs of multi_ce_gen.
interface multi_ce_gen_if import uk101_ce_pkg::*; #(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
);
    logic [NUM_CH-1:0]       enable;
    logic [NUM_CH-1:0]       frac_mode;
    logic [NUM_CH*CNT_W-1:0] div;
    logic [NUM_CH*ACC_W-1:0] frac_inc;
    logic                    sync_restart;
    logic [NUM_CH-1:0]       ce;
    logic [NUM_CH-1:0]       upd_ack;
    modport master (output enable, frac_mode, div, frac_inc, sync_restart, input ce, upd_ack);
    modport slave (input enable, frac_mode, div, frac_inc, sync_restart, output ce, upd_ack);
endinterface

// File: rtl/multi_ce_gen_chan.sv
// ce_chan: one clock-enable channel, integer divider or fractional phase accumulator.
module ce_chan import uk101_ce_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sync_i,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic [ACC_W-1:0] inc_i,
    output logic             ce_o,
    output logic             ack_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d, act_q, act_d;
    logic [ACC_W-1:0] acc_q, acc_d, sum;
    logic             carry, ce_q, ce_d, ack_q, ack_d;
    ce_mode_e         mode, mode_q;
    assign mode = ce_mode_e'(mode_i);
    assign {carry, sum} = {1'b0, acc_q} + {1'b0, inc_i};
    // act_div only moves when the count restarts from 0, so a live period is never altered
    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        act_d = act_q;
        ce_d  = 1'b0;
        ack_d = 1'b0;
        if (sync_i || !en_i) begin
            cnt_d = '0;
            acc_d = '0;
            act_d = div_i;
            ack_d = div_i != act_q;
        end else if (mode != mode_q) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (mode == CE_FRAC) begin
            acc_d = sum;
            ce_d  = carry;
        end else if (cnt_q == act_q) begin
            cnt_d = '0;
            ce_d  = 1'b1;
            act_d = div_i;
            ack_d = div_i != act_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            act_q  <= div_i;
            mode_q <= mode;
            ce_q   <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            act_q  <= act_d;
            mode_q <= mode;
            ce_q   <= ce_d;
            ack_q  <= ack_d;
        end
    end
    assign ce_o  = ce_q;
    assign ack_o = ack_q;
endmodule

// File: rtl/multi_ce_gen.sv
// multi_ce_gen: NUM_CH independent clock-enable channels sharing reset and sync_restart.
module multi_ce_gen import uk101_ce_pkg::*; #(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input logic           clk_sys,
    input logic           reset,
    multi_ce_gen_if.slave bus
);
    logic [NUM_CH-1:0] ce_w, ack_w;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ce_chan #(.CNT_W(CNT_W), .ACC_W(ACC_W)) u_ch (
            .clk_i (clk_sys),
            .rst_i (reset),
            .sync_i(bus.sync_restart),
            .en_i  (bus.enable[i]),
            .mode_i(bus.frac_mode[i]),
            .div_i (bus.div[i*CNT_W +: CNT_W]),
            .inc_i (bus.frac_inc[i*ACC_W +: ACC_W]),
            .ce_o  (ce_w[i]),
            .ack_o (ack_w[i])
        );
    end
    assign bus.ce      = ce_w;
    assign bus.upd_ack = ack_w;
endmodule

// File: tb/tb_multi_ce_gen.sv
// tb_multi_ce_gen: directed stimulus with per-edge expectations queued to a negedge monitor.
module tb_multi_ce_gen;
    typedef struct {
        logic [2:0] ce;
        logic [2:0] ack;
        logic [2:0] m;
        int         tag;
    } exp_t;

    logic clk_sys = 1'b0;
    logic reset;
    exp_t sb[$];
    int   n_chk = 0, n_fail = 0, n1 = 0, consec = 0;
    logic prev1 = 1'b0, done = 1'b0;

    always #5 clk_sys = ~clk_sys;

    multi_ce_gen_if #(.NUM_CH(3), .CNT_W(8), .ACC_W(16)) bus ();
    multi_ce_gen #(.NUM_CH(3), .CNT_W(8), .ACC_W(16)) dut (
        .clk_sys(clk_sys),
        .reset  (reset),
        .bus    (bus)
    );

    task automatic tick(input logic [2:0] ce_e, input logic [2:0] ack_e, input logic [2:0] m, input int tag);
        exp_t e;
        @(posedge clk_sys);
        e.ce  = ce_e;
        e.ack = ack_e;
        e.m   = m;
        e.tag = tag;
        sb.push_back(e);
        #1;
    endtask

    task automatic do_reset(input int tag);
        reset = 1'b1;
        tick(3'b000, 3'b000, 3'b111, tag);
        tick(3'b000, 3'b000, 3'b111, tag);
        reset = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk_sys);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.tag == 4) begin
                    if (bus.ce[1]) begin
                        n1++;
                        if (prev1) consec++;
                    end
                    prev1 = bus.ce[1];
                end
                if (e.tag == 99) begin
                    n_chk++;
                    if (n1 != 21845) begin
                        n_fail++;
                        $display("FAIL frac_5555_count got %0d want 21845", n1);
                    end
                    n_chk++;
                    if (consec != 0) begin
                        n_fail++;
                        $display("FAIL frac_5555_consecutive got %0d want 0", consec);
                    end
                end else if (e.tag == 999) begin
                    done = 1'b1;
                end else begin
                    n_chk++;
                    if ((bus.ce & e.m) !== (e.ce & e.m)) begin
                        n_fail++;
                        $display("FAIL ce test=%0d t=%0t got %b want %b mask %b", e.tag, $time, bus.ce, e.ce, e.m);
                    end
                    n_chk++;
                    if ((bus.upd_ack & e.m) !== (e.ack & e.m)) begin
                        n_fail++;
                        $display("FAIL upd_ack test=%0d t=%0t got %b want %b mask %b", e.tag, $time, bus.upd_ack, e.ack, e.m);
                    end
                end
            end
        end
    end

    initial begin
        bus.sync_restart = 1'b0;
        bus.frac_inc = '0;
        // integer divide: ch0=5, ch1=11, ch2=0
        bus.enable = 3'b111;
        bus.frac_mode = 3'b000;
        bus.div = {8'd0, 8'd11, 8'd5};
        do_reset(1);
        for (int k = 1; k <= 36; k++)
            tick({1'b1, k % 12 == 0, k % 6 == 0}, 3'b000, 3'b111, 1);
        // mid-period change 11 -> 5 at count 3
        bus.enable = 3'b001;
        bus.div = {8'd0, 8'd0, 8'd11};
        do_reset(2);
        for (int k = 1; k <= 36; k++) begin
            tick({2'b00, k == 12 || (k > 12 && (k - 12) % 6 == 0)}, {2'b00, k == 12}, 3'b111, 2);
            if (k == 3) bus.div[7:0] = 8'd5;
        end
        // desynchronise ch1, then sync_restart realigns
        bus.enable = 3'b011;
        bus.div = {8'd0, 8'd5, 8'd5};
        do_reset(3);
        for (int k = 1; k <= 26; k++) begin
            tick({1'b0,
                  k < 14 ? k == 11 : k > 14 && (k - 14) % 6 == 0,
                  k < 14 ? k % 6 == 0 : k > 14 && (k - 14) % 6 == 0}, 3'b000, 3'b111, 3);
            if (k == 3) bus.enable = 3'b001;
            if (k == 5) bus.enable = 3'b011;
            if (k == 13) bus.sync_restart = 1'b1;
            if (k == 14) bus.sync_restart = 1'b0;
        end
        // fractional: ch0 inc 0x8000, ch1 inc 0x5555
        bus.enable = 3'b011;
        bus.frac_mode = 3'b011;
        bus.div = '0;
        bus.frac_inc = {16'h0000, 16'h5555, 16'h8000};
        do_reset(40);
        for (int k = 1; k <= 65536; k++)
            tick({2'b00, k % 2 == 0}, 3'b000, 3'b101, 4);
        tick(3'b000, 3'b000, 3'b000, 99);
        // div = 255 on ch2
        bus.enable = 3'b100;
        bus.frac_mode = 3'b000;
        bus.frac_inc = '0;
        bus.div = {8'd255, 8'd0, 8'd0};
        do_reset(5);
        for (int k = 1; k <= 512; k++)
            tick({k % 256 == 0, 2'b00}, 3'b000, 3'b111, 5);
        // disable at count 4 with a divisor change while disabled
        bus.enable = 3'b001;
        bus.div = {8'd0, 8'd0, 8'd5};
        do_reset(6);
        for (int k = 1; k <= 17; k++) begin
            tick({2'b00, k == 9 || k == 13 || k == 17}, {2'b00, k == 5}, 3'b111, 6);
            if (k == 4) begin
                bus.enable = 3'b000;
                bus.div[7:0] = 8'd3;
            end
            if (k == 5) bus.enable = 3'b001;
        end
        // reset together with sync_restart and a divisor change
        bus.div = {8'd0, 8'd0, 8'd3};
        do_reset(7);
        for (int k = 1; k <= 6; k++)
            tick({2'b00, k == 4}, 3'b000, 3'b111, 7);
        reset = 1'b1;
        bus.sync_restart = 1'b1;
        bus.div[7:0] = 8'd7;
        tick(3'b000, 3'b000, 3'b111, 7);
        reset = 1'b0;
        bus.sync_restart = 1'b0;
        for (int k = 1; k <= 16; k++)
            tick({2'b00, k == 8 || k == 16}, 3'b000, 3'b111, 7);
        // frac_mode toggles on ch0
        bus.frac_mode = 3'b001;
        bus.frac_inc = {16'h0000, 16'h0000, 16'h8000};
        bus.div = {8'd0, 8'd0, 8'd2};
        do_reset(8);
        for (int k = 1; k <= 13; k++) begin
            tick({2'b00, k == 2 || k == 7 || k == 11 || k == 13}, 3'b000, 3'b111, 8);
            if (k == 3) bus.frac_mode = 3'b000;
            if (k == 8) bus.frac_mode = 3'b001;
        end
        tick(3'b000, 3'b000, 3'b000, 999);
        for (int w = 0; w < 10 && !done; w++) @(negedge clk_sys);
        if (!done) begin
            $display("FAIL drain scoreboard left %0d entries want 0", sb.size());
            $fatal(1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
